// File: rtl/posit_fr_mult_pipe_if.sv
// posit_fr_mult_pipe_if
//  Operand/result bundle for the fixed-regime posit multiplier.
//  Handshake: a beat moves across a channel on the rising clk edge where both
//  its valid and its ready are high. The producer holds data stable while
//  valid is high and ready is low; ready may depend combinationally on the
//  consumer state but never on valid from the same channel.
//  Signals:
//   in_valid / in_ready / a / b                  operand channel (master -> slave)
//   out_valid / out_ready / out                  result channel  (slave -> master)
//   out_nar / out_zero / out_sat                 result flags, qualified by out_valid
//  Modports: master = operand source / result sink, slave = multiplier.
interface posit_fr_mult_pipe_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         out_nar;
  logic         out_zero;
  logic         out_sat;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, out_nar, out_zero, out_sat
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, out_nar, out_zero, out_sat
  );
endinterface

// File: rtl/posit_fr_mult_pipe.sv
// posit_fr_mult_pipe
//  Three-stage pipelined multiplier for fixed-regime posits laid out as
//  sign | RS-bit biased regime | ES-bit exponent | F-bit fraction.
//  Round-to-nearest-even, saturation to maxpos/minpos, NaR and zero flags.
//  Ports:
//   clk    clock
//   reset  synchronous, active-high; drops all in-flight data
//   bus    posit_fr_mult_pipe_if.slave (operands in, product + flags out)
//  Stages: S1 decoded operand fields, S2 raw product + scale sum,
//  S3 rounded/encoded word + flags (the output register). All stages move
//  together on advance = !out_valid | out_ready, so a stalled pipe holds
//  everything stable and a flowing pipe accepts one pair per cycle.
module posit_fr_mult_pipe #(
  parameter int N  = 8,
  parameter int ES = 2,
  parameter int RS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  posit_fr_mult_pipe_if.slave   bus
);

  localparam int F  = N - 1 - RS - ES;
  localparam int SW = RS + ES + 3;
  localparam int PW = 2 * F + 2;

  localparam int SCALE_MAX = ((1 << (RS - 1)) - 1) * (1 << ES) + (1 << ES) - 1;
  localparam int SCALE_MIN = -((1 << (RS - 1)) * (1 << ES));

  localparam logic signed [SW-1:0] SMAX  = SW'(SCALE_MAX);
  localparam logic signed [SW-1:0] SMIN  = SW'(SCALE_MIN);
  localparam logic signed [SW-1:0] RBIAS = SW'(1 << (RS - 1));
  localparam logic [N-1:0]         NAR_W = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-2:0]         MAXPOS_M = '1;
  localparam logic [N-2:0]         MINPOS_M = (N-1)'(1);

  typedef struct packed {
    logic          sign;
    logic          nar;
    logic          zero;
    logic [F-1:0]  frac;
    logic [SW-1:0] scale;
  } dec_t;

  // Negative words are decoded from their two's-complement magnitude.
  function automatic dec_t decode(input logic [N-1:0] w);
    dec_t                  d;
    logic [N-1:0]          neg;
    logic [N-2:0]          m;
    logic [RS-1:0]         r;
    logic [ES-1:0]         e;
    logic signed [SW-1:0]  k;
    neg     = ~w + N'(1);
    m       = w[N-1] ? neg[N-2:0] : w[N-2:0];
    r       = m[N-2 -: RS];
    e       = m[N-2-RS -: ES];
    k       = $signed({{(SW-RS){1'b0}}, r}) - RBIAS;
    d.sign  = w[N-1];
    d.nar   = (w == NAR_W);
    d.zero  = (w == '0);
    d.frac  = m[F-1:0];
    d.scale = (k <<< ES) + $signed({{(SW-ES){1'b0}}, e});
    return d;
  endfunction

  dec_t da;
  dec_t db;
  assign da = decode(bus.a);
  assign db = decode(bus.b);

  logic advance;
  logic out_valid_q;
  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // S1: decoded fields
  logic          s1_valid;
  logic          s1_nar;
  logic          s1_zero;
  logic          s1_sign;
  logic [F-1:0]  s1_fa;
  logic [F-1:0]  s1_fb;
  logic [SW-1:0] s1_sa;
  logic [SW-1:0] s1_sb;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_nar   <= da.nar | db.nar;
      s1_zero  <= da.zero | db.zero;
      s1_sign  <= da.sign ^ db.sign;
      s1_fa    <= da.frac;
      s1_fb    <= db.frac;
      s1_sa    <= da.scale;
      s1_sb    <= db.scale;
    end
  end

  // S2: significand product and unnormalised scale
  logic          s2_valid;
  logic          s2_nar;
  logic          s2_zero;
  logic          s2_sign;
  logic [PW-1:0] s2_prod;
  logic [SW-1:0] s2_scale;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_nar   <= s1_nar;
      s2_zero  <= s1_zero;
      s2_sign  <= s1_sign;
      s2_prod  <= PW'({1'b1, s1_fa}) * PW'({1'b1, s1_fb});
      s2_scale <= s1_sa + s1_sb;
    end
  end

  // S3 combinational: normalise, round, clamp, encode
  logic [PW-1:0]        norm;
  logic [F-1:0]         frac_t;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [F:0]           frac_sum;
  logic signed [SW-1:0] scale_r;
  logic signed [SW-1:0] r_enc;
  logic [N-2:0]         mag;
  logic [N-1:0]         word;
  logic                 nar_c;
  logic                 zero_c;
  logic                 sat_c;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4); shifting the [1,2)
    // case up puts the hidden one at PW-1 for both, so one slice serves.
    norm     = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
    frac_t   = norm[PW-2 -: F];
    guard    = norm[F];
    sticky   = |norm[F-1:0];
    round_up = guard & (sticky | frac_t[0]);
    frac_sum = {1'b0, frac_t} + (F+1)'(round_up);
    // frac_sum[F] set means the fraction wrapped to zero: bump the scale.
    scale_r  = $signed(s2_scale)
             + $signed(SW'(s2_prod[PW-1]))
             + $signed(SW'(frac_sum[F]));
    r_enc    = (scale_r >>> ES) + RBIAS;
    mag      = {r_enc[RS-1:0], scale_r[ES-1:0], frac_sum[F-1:0]};
    sat_c    = 1'b0;
    nar_c    = 1'b0;
    zero_c   = 1'b0;
    if (scale_r > SMAX) begin
      mag   = MAXPOS_M;
      sat_c = 1'b1;
    end else if ((scale_r < SMIN) || (mag == '0)) begin
      // The all-zero magnitude is the zero encoding, so clamp to minpos.
      mag   = MINPOS_M;
      sat_c = 1'b1;
    end
    word = s2_sign ? (~{1'b0, mag} + N'(1)) : {1'b0, mag};
    if (s2_nar) begin
      word  = NAR_W;
      nar_c = 1'b1;
      sat_c = 1'b0;
    end else if (s2_zero) begin
      word   = '0;
      zero_c = 1'b1;
      sat_c  = 1'b0;
    end
  end

  // S3 register: output word and flags
  logic [N-1:0] out_q;
  logic         nar_q;
  logic         zero_q;
  logic         sat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      nar_q       <= 1'b0;
      zero_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_q  <= word;
        nar_q  <= nar_c;
        zero_q <= zero_c;
        sat_q  <= sat_c;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_nar   = nar_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_posit_fr_mult_pipe.sv
// tb_posit_fr_mult_pipe
//  Bench for posit_fr_mult_pipe at N=8, ES=2, RS=2. Expected results are
//  {out, nar, zero, sat} words pushed when a pair is accepted and popped by
//  the output monitor on each result transfer.
module tb_posit_fr_mult_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  posit_fr_mult_pipe_if #(.N(8)) bus ();

  posit_fr_mult_pipe #(.N(8), .ES(2), .RS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [10:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  string       cur_test = "init";

  // Reference: integer arithmetic on value = 2^scale * (8+f)/8.
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y);
    int mx, my, sx, sy, fx, fy, p, sc, q, rem, half, mag, res;
    logic sat;
    logic [7:0] r8;
    if (x == 8'h80 || y == 8'h80) return {8'h80, 3'b100};
    if (x == 8'h00 || y == 8'h00) return {8'h00, 3'b010};
    mx = x[7] ? ((256 - int'(x)) & 127) : (int'(x) & 127);
    my = y[7] ? ((256 - int'(y)) & 127) : (int'(y) & 127);
    sx = (mx >> 5) * 4 + ((mx >> 3) & 3) - 8;
    sy = (my >> 5) * 4 + ((my >> 3) & 3) - 8;
    fx = mx & 7;
    fy = my & 7;
    p  = (8 + fx) * (8 + fy);
    sc = sx + sy;
    if (p >= 128) begin
      q = p / 16; rem = p % 16; half = 8; sc = sc + 1;
    end else begin
      q = p / 8;  rem = p % 8;  half = 4;
    end
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == 16) begin q = 8; sc = sc + 1; end
    sat = 1'b0;
    if (sc > 7) begin
      mag = 127; sat = 1'b1;
    end else if (sc < -8) begin
      mag = 1; sat = 1'b1;
    end else begin
      mag = ((sc + 8) >> 2) * 32 + ((sc + 8) & 3) * 8 + (q - 8);
      if (mag == 0) begin mag = 1; sat = 1'b1; end
    end
    res = (x[7] ^ y[7]) ? ((256 - mag) & 255) : mag;
    r8  = res[7:0];
    return {r8, 1'b0, 1'b0, sat};
  endfunction

  function automatic logic [7:0] pick_operand();
    logic [7:0] sp[7];
    sp = '{8'h00, 8'h80, 8'h7F, 8'h01, 8'h81, 8'hFF, 8'h40};
    if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 6)];
    return 8'($urandom_range(0, 255));
  endfunction

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      logic [10:0] got;
      logic [10:0] e;
      got = {bus.out, bus.out_nar, bus.out_zero, bus.out_sat};
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected_result got=%h expected none", cur_test, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL %s result out=%h nar/zero/sat=%b expected out=%h nar/zero/sat=%b",
                   cur_test, got[10:3], got[2:0], e[10:3], e[2:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [10:0] e);
    int n;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s accept_timeout in_ready=%b expected 1", cur_test, bus.in_ready);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain_timeout pending=%0d expected 0", cur_test, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset out_valid=%b expected 0", bus.out_valid);
    end
    checks++;
    if ({bus.out, bus.out_nar, bus.out_zero, bus.out_sat} !== 11'h000) begin
      errors++;
      $display("FAIL reset outputs out=%h flags=%b expected 00 000", bus.out,
               {bus.out_nar, bus.out_zero, bus.out_sat});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset in_ready=%b expected 1", bus.in_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Directed vectors, sent back-to-back with the sink always ready.
  task automatic test_directed();
    logic [7:0]  ta[15];
    logic [7:0]  tb2[15];
    logic [10:0] te[15];
    cur_test = "directed";
    ta  = '{8'h40, 8'h44, 8'hC0, 8'h41, 8'h41, 8'h7F, 8'h01, 8'h81,
            8'h80, 8'h00, 8'h08, 8'h78, 8'h7F, 8'hC0, 8'h44};
    tb2 = '{8'h40, 8'h44, 8'h40, 8'h44, 8'h41, 8'h7F, 8'h01, 8'h7F,
            8'h00, 8'h44, 8'h38, 8'h40, 8'h40, 8'hC0, 8'h80};
    te  = '{{8'h40, 3'b000}, {8'h49, 3'b000}, {8'hC0, 3'b000}, {8'h46, 3'b000},
            {8'h42, 3'b000}, {8'h7F, 3'b001}, {8'h01, 3'b001}, {8'h81, 3'b001},
            {8'h80, 3'b100}, {8'h00, 3'b010}, {8'h01, 3'b001}, {8'h78, 3'b000},
            {8'h7F, 3'b000}, {8'h40, 3'b000}, {8'h80, 3'b100}};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(ta[i], tb2[i], te[i]);
    drain();
  endtask

  // Fill a stalled pipe, check it holds, then release at full rate.
  task automatic test_flow();
    logic [7:0]  pa[5];
    logic [7:0]  pb[5];
    logic [10:0] first;
    logic        took;
    int          idx;
    int          acc;
    int          n0;
    cur_test = "flow";
    pa = '{8'h44, 8'h41, 8'h7F, 8'hC0, 8'h08};
    pb = '{8'h44, 8'h44, 8'h7F, 8'h40, 8'h38};
    bus.out_ready = 1'b0;
    idx = 0;
    acc = 0;
    bus.a = pa[0];
    bus.b = pb[0];
    bus.in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (took) begin
        exp_q.push_back(model(pa[idx], pb[idx]));
        acc++;
      end
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 5) begin bus.a = pa[idx]; bus.b = pb[idx]; end
        else bus.in_valid = 1'b0;
      end
    end
    checks++;
    if (acc != 3) begin
      errors++; $display("FAIL flow accepted=%0d expected 3", acc);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flow stalled_in_ready=%b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL flow stalled_out_valid=%b expected 1", bus.out_valid);
    end
    first = model(pa[0], pb[0]);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.out, bus.out_nar, bus.out_zero, bus.out_sat} !== first) begin
        errors++;
        $display("FAIL flow stall_hold out=%h flags=%b expected out=%h flags=%b", bus.out,
                 {bus.out_nar, bus.out_zero, bus.out_sat}, first[10:3], first[2:0]);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    n0 = n_out;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL flow stream_out_valid=%b expected 1", bus.out_valid);
      end
      took = bus.in_valid && bus.in_ready;
      if (took) exp_q.push_back(model(pa[idx], pb[idx]));
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 5) begin bus.a = pa[idx]; bus.b = pb[idx]; end
        else bus.in_valid = 1'b0;
      end
    end
    checks++;
    if (n_out - n0 != 5) begin
      errors++; $display("FAIL flow stream_count=%0d expected 5", n_out - n0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int n0;
    cur_test = "reset_mid";
    bus.out_ready = 1'b0;
    send(8'h44, 8'h44, model(8'h44, 8'h44));
    send(8'h7F, 8'h7F, model(8'h7F, 8'h7F));
    send(8'h80, 8'h00, model(8'h80, 8'h00));
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid out_valid=%b expected 0", bus.out_valid);
    end
    checks++;
    if ({bus.out, bus.out_nar, bus.out_zero, bus.out_sat} !== 11'h000) begin
      errors++;
      $display("FAIL reset_mid outputs out=%h flags=%b expected 00 000", bus.out,
               {bus.out_nar, bus.out_zero, bus.out_sat});
    end
    exp_q.delete();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    n0 = n_out;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_out != n0) begin
      errors++; $display("FAIL reset_mid stale_results=%0d expected 0", n_out - n0);
    end
  endtask

  // Random operands and random sink backpressure.
  task automatic test_random();
    logic took;
    cur_test = "random";
    bus.in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        bus.a = pick_operand();
        bus.b = pick_operand();
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (took) exp_q.push_back(model(bus.a, bus.b));
      @(posedge clk); #1;
      if (took) bus.in_valid = 1'b0;
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_flow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
